// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the icache, dcache and shared-memory handshake/bus signals.
// Latency: none (wiring only).
// Backpressure: carried by the en/rdy pairs; slave = arbiter side, master = requesters + memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // instruction-fetch port
  logic              icache_en;
  logic [ADDR_W-1:0] icache_addr;
  logic [DATA_W-1:0] icache_data;
  logic              icache_rdy;

  // data port
  logic              dcache_en;
  logic              dcache_wr;
  logic [ADDR_W-1:0] dcache_addr;
  logic [DATA_W-1:0] dcache_wdata;
  logic [DATA_W-1:0] dcache_rdata;
  logic              dcache_rdy;

  // shared memory port
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rdy;

  // arbiter view
  modport slave (
    input  icache_en, icache_addr,
    output icache_data, icache_rdy,
    input  dcache_en, dcache_wr, dcache_addr, dcache_wdata,
    output dcache_rdata, dcache_rdy,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_rdy
  );

  // requester + memory view
  modport master (
    output icache_en, icache_addr,
    input  icache_data, icache_rdy,
    output dcache_en, dcache_wr, dcache_addr, dcache_wdata,
    input  dcache_rdata, dcache_rdy,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_rdy
  );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates icache fetches and dcache loads/stores onto one shared memory port.
// Latency: 3 cycles minimum request->rdy (IDLE sample, grant, RESP); one transaction per 3 cycles.
// Backpressure: a grant waits indefinitely for mem_rdy; requesters hold en until their rdy pulse.
// Build option: MEM_ARB_RR_EN -> ties resolved round-robin; undefined -> dcache always wins ties.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic         clock,
  input  logic         resetn,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            state_q, state_d;

  // shared-memory request, launched only from these latched values
  logic              mem_en_q, mem_en_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  // requester responses; data registers hold between transactions
  logic              icache_rdy_q, icache_rdy_d;
  logic              dcache_rdy_q, dcache_rdy_d;
  logic [DATA_W-1:0] icache_data_q, icache_data_d;
  logic [DATA_W-1:0] dcache_rdata_q, dcache_rdata_d;

  // tie-break direction and the resulting grant decision in IDLE
  logic              tie_to_d;
  logic              grant_d;
  logic              grant_i;

`ifdef MEM_ARB_RR_EN
  // 1 when the most recent grant went to dcache; reset leaves it 0 so dcache wins the first tie
  logic              last_d_q, last_d_d;

  assign tie_to_d = ~last_d_q;
`else
  assign tie_to_d = 1'b1;
`endif

  // single requester always wins; on a tie the tie-break direction decides
  always_comb begin
    grant_d = bus.dcache_en & (~bus.icache_en | tie_to_d);
    grant_i = bus.icache_en & ~grant_d;
  end

  // next-state and registered-output computation
  always_comb begin
    state_d        = state_q;
    mem_en_d       = mem_en_q;
    mem_wr_d       = mem_wr_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    icache_rdy_d   = 1'b0;
    dcache_rdy_d   = 1'b0;
    icache_data_d  = icache_data_q;
    dcache_rdata_d = dcache_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_d_d       = last_d_q;
`endif

    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d     = DGNT;
          mem_en_d    = 1'b1;
          mem_wr_d    = bus.dcache_wr;
          mem_addr_d  = bus.dcache_addr;
          mem_wdata_d = bus.dcache_wdata;
`ifdef MEM_ARB_RR_EN
          last_d_d    = 1'b1;
`endif
        end else if (grant_i) begin
          // fetches never write; store data is parked at zero
          state_d     = IGNT;
          mem_en_d    = 1'b1;
          mem_wr_d    = 1'b0;
          mem_addr_d  = bus.icache_addr;
          mem_wdata_d = '0;
`ifdef MEM_ARB_RR_EN
          last_d_d    = 1'b0;
`endif
        end
      end

      IGNT: begin
        if (bus.mem_rdy) begin
          state_d       = RESP;
          mem_en_d      = 1'b0;
          mem_wr_d      = 1'b0;
          icache_data_d = bus.mem_rdata;
          icache_rdy_d  = 1'b1;
        end
      end

      DGNT: begin
        if (bus.mem_rdy) begin
          state_d      = RESP;
          mem_en_d     = 1'b0;
          mem_wr_d     = 1'b0;
          dcache_rdy_d = 1'b1;
          // a store completes without touching the load-data register
          if (!mem_wr_q) begin
            dcache_rdata_d = bus.mem_rdata;
          end
        end
      end

      RESP: begin
        // requester enables are deliberately not looked at here
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and output registers; reset abandons any in-flight transaction
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      mem_en_q       <= 1'b0;
      mem_wr_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      icache_rdy_q   <= 1'b0;
      dcache_rdy_q   <= 1'b0;
      icache_data_q  <= '0;
      dcache_rdata_q <= '0;
    end else begin
      state_q        <= state_d;
      mem_en_q       <= mem_en_d;
      mem_wr_q       <= mem_wr_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      icache_rdy_q   <= icache_rdy_d;
      dcache_rdy_q   <= dcache_rdy_d;
      icache_data_q  <= icache_data_d;
      dcache_rdata_q <= dcache_rdata_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  // round-robin pointer register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`endif

  assign bus.mem_en       = mem_en_q;
  assign bus.mem_wr       = mem_wr_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.icache_rdy   = icache_rdy_q;
  assign bus.icache_data  = icache_data_q;
  assign bus.dcache_rdy   = dcache_rdy_q;
  assign bus.dcache_rdata = dcache_rdata_q;

  // completion pulses belong to different transactions and can never coincide
  a_rdy_exclusive: assert property (@(posedge clock) disable iff (!resetn)
    !(icache_rdy_q && dcache_rdy_q));

  // the memory request is live exactly while a grant is outstanding
  a_mem_en_in_grant: assert property (@(posedge clock) disable iff (!resetn)
    mem_en_q == ((state_q == IGNT) || (state_q == DGNT)));

  // a completion pulse only appears in the response cycle
  a_rdy_in_resp: assert property (@(posedge clock) disable iff (!resetn)
    (icache_rdy_q || dcache_rdy_q) |-> (state_q == RESP));

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL: ADDR_W, 32, address width of all ports.
REQ-002 SHALL: DATA_W, 32, data width of all ports.
REQ-003 SHALL: clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL: resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL: icache_en  input  1  instruction-fetch request, held high until icache_rdy.
REQ-006 SHALL: icache_addr  input  ADDR_W  fetch address, stable while icache_en is high.
REQ-007 SHALL: icache_data  output  DATA_W  fetched word, valid in the icache_rdy cycle.
REQ-008 SHALL: icache_rdy  output  1  one-cycle completion pulse for the fetch.
REQ-009 SHALL: dcache_en  input  1  data request, held high until dcache_rdy.
REQ-010 SHALL: dcache_wr  input  1  1=write, 0=read; stable with dcache_en.
REQ-011 SHALL: dcache_addr  input  ADDR_W  data address.
REQ-012 SHALL: dcache_wdata  input  DATA_W  store data.
REQ-013 SHALL: dcache_rdata  output  DATA_W  load data, valid in the dcache_rdy cycle.
REQ-014 SHALL: dcache_rdy  output  1  one-cycle completion pulse for the data request.
REQ-015 SHALL: mem_en, mem_wr  output  1 each  shared-memory request and write strobe.
REQ-016 SHALL: mem_addr  output  ADDR_W; mem_wdata  output  DATA_W  shared-memory address and store data.
REQ-017 SHALL: mem_rdata  input  DATA_W; mem_rdy  input  1  memory read data and completion, valid in the same cycle.

Function
REQ-018 SHALL: the FSM has four states: IDLE, IGNT, DGNT and RESP.
REQ-019 SHALL: IDLE with no request stays in IDLE; only icache_en goes to IGNT; only dcache_en goes to DGNT; both high resolves per REQ-028.
REQ-020 SHALL: on entering IGNT/DGNT, the winner's address, wr and wdata are latched; mem_* outputs are registered and driven only from the latched values.
REQ-021 SHALL: mem_en is 1 exactly in IGNT/DGNT; mem_wr is 0 in IGNT and equals the latched dcache_wr in DGNT.
REQ-022 SHALL: in IGNT/DGNT with mem_rdy=1, mem_rdata is captured into the granted requester's data register, the FSM goes to RESP, and the granted rdy output is 1 in the RESP cycle.
REQ-023 SHALL: on a write, dcache_rdata is not updated.
REQ-024 SHALL: in IGNT/DGNT, mem_rdy=0 holds the state and all mem_* outputs unchanged, with no cycle limit.
REQ-025 SHALL: RESP lasts exactly one cycle, then IDLE; requester enables are ignored in RESP, so a requester must drop or renew its request by the edge ending RESP.
REQ-026 SHALL: minimum latency is 3 cycles from request to rdy (IDLE sample, grant with mem_rdy same cycle, RESP); back-to-back throughput is one transaction per 3 cycles.
REQ-027 SHALL: icache_data and dcache_rdata hold their last captured value between transactions; rdy pulses never overlap.

Reset
REQ-029 SHALL: resetn=0 immediately forces state IDLE; mem_en, mem_wr, icache_rdy and dcache_rdy go to 0; mem_addr, mem_wdata, icache_data and dcache_rdata go to 0; the round-robin pointer is set to favour dcache.
REQ-030 SHALL: reset asserted during IGNT/DGNT abandons the transaction: no rdy is issued, and a mem_rdy arriving after reset is ignored.

Configuration
REQ-028 SHALL: with MEM_ARB_RR_EN defined, simultaneous requests are granted round-robin (the requester not granted last wins; the pointer updates on every grant); without MEM_ARB_RR_EN, dcache always wins ties.
REQ-031 SHALL: MEM_ARB_RR_EN affects only tie resolution; single-requester behaviour and timing are identical in both builds.

Verification
REQ-032 SHALL: icache_en=1 with addr 0x100, and mem_rdy=1 in the first IGNT cycle with rdata 0xDEADBEEF -> mem_en for 1 cycle with mem_addr 0x100 and mem_wr=0, then icache_rdy=1 with icache_data 0xDEADBEEF on cycle 3.
REQ-033 SHALL: dcache write of addr 0x200, wdata 0x12345678, with mem_rdy delayed 4 cycles -> mem_wr=1 and mem_* stable for 5 cycles, one dcache_rdy pulse, dcache_rdata unchanged.
REQ-034 SHALL: both requesters continuously requesting for 6 transactions -> without MEM_ARB_RR_EN, dcache is granted all 6; with it, grants alternate D,I,D,I,D,I.
REQ-035 SHALL: resetn pulled low in DGNT while mem_rdy=0, then mem_rdy=1 after release -> no dcache_rdy, state IDLE, all outputs 0.
REQ-036 SHALL: a requester keeps en high through RESP -> it is re-arbitrated only in the following IDLE cycle, with no duplicate rdy.
